// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: SYNC, LSB-first shifting, bit stuffing, NRZI and EOP.
// Define USB_TX_CRC16_EN to append a CRC16 (over every byte after the PID) before EOP.
module usb_tx_serializer #(
   parameter int unsigned       DATA_W       = 8,
   parameter int unsigned       CLKS_PER_BIT = 4,
   parameter int unsigned       STUFF_RUN    = 6,
   parameter logic [DATA_W-1:0] SYNC_PATTERN = DATA_W'(8'h80)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   output logic              tx_ready,
   output logic              dp_out,
   output logic              dm_out,
   output logic              tx_oe,
   output logic              busy,
   output logic              underrun
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
   localparam int unsigned ONES_W = $clog2(STUFF_RUN + 1);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_t;

   state_t              state_q, state_n;
   logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_n;
   logic [DATA_W-1:0]   shreg_q, shreg_n;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_n;
   logic [ONES_W-1:0]   ones_q, ones_n;
   logic [1:0]          eop_cnt_q, eop_cnt_n;
   logic                lvl_q, lvl_n;
   logic [DATA_W-1:0]   hold_q, hold_n;
   logic                hold_full_q, hold_full_n;
   logic                last_acc_q, last_acc_n;
   logic                tx_ready_n, dp_n, dm_n, oe_n, busy_n, underrun_n;

   logic                accept, strobe, snd, snd_bit, load, drain;
   logic [DATA_W-1:0]   load_byte;

`ifdef USB_TX_CRC16_EN
   logic [15:0]         crc_q, crc_n;
   logic                pid_seen_q, pid_seen_n;
   logic [1:0]          crc_idx_q, crc_idx_n;

   // Reflected CRC16 (poly 0x8005 -> 0xA001), data consumed LSB first.
   function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [DATA_W-1:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < int'(DATA_W); i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
      end
      return r;
   endfunction
`endif

   // State and datapath register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         clk_cnt_q   <= '0;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         ones_q      <= '0;
         eop_cnt_q   <= '0;
         lvl_q       <= 1'b1;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         last_acc_q  <= 1'b0;
         tx_ready    <= 1'b0;
         dp_out      <= 1'b1;
         dm_out      <= 1'b0;
         tx_oe       <= 1'b0;
         busy        <= 1'b0;
         underrun    <= 1'b0;
`ifdef USB_TX_CRC16_EN
         crc_q       <= '1;
         pid_seen_q  <= 1'b0;
         crc_idx_q   <= '0;
`endif
      end else begin
         state_q     <= state_n;
         clk_cnt_q   <= clk_cnt_n;
         shreg_q     <= shreg_n;
         bit_cnt_q   <= bit_cnt_n;
         ones_q      <= ones_n;
         eop_cnt_q   <= eop_cnt_n;
         lvl_q       <= lvl_n;
         hold_q      <= hold_n;
         hold_full_q <= hold_full_n;
         last_acc_q  <= last_acc_n;
         tx_ready    <= tx_ready_n;
         dp_out      <= dp_n;
         dm_out      <= dm_n;
         tx_oe       <= oe_n;
         busy        <= busy_n;
         underrun    <= underrun_n;
`ifdef USB_TX_CRC16_EN
         crc_q       <= crc_n;
         pid_seen_q  <= pid_seen_n;
         crc_idx_q   <= crc_idx_n;
`endif
      end
   end

   // Next state: decides which bit goes on the line at each strobe
   always_comb begin
      state_n     = state_q;
      clk_cnt_n   = clk_cnt_q;
      shreg_n     = shreg_q;
      bit_cnt_n   = bit_cnt_q;
      ones_n      = ones_q;
      eop_cnt_n   = eop_cnt_q;
      lvl_n       = lvl_q;
      hold_n      = hold_q;
      last_acc_n  = last_acc_q;
      dp_n        = dp_out;
      dm_n        = dm_out;
      underrun_n  = 1'b0;
      snd         = 1'b0;
      snd_bit     = 1'b0;
      load        = 1'b0;
      load_byte   = hold_q;
      drain       = 1'b0;
      accept      = tx_valid & tx_ready;
      strobe      = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
`ifdef USB_TX_CRC16_EN
      crc_n       = crc_q;
      pid_seen_n  = pid_seen_q;
      crc_idx_n   = crc_idx_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               state_n    = S_SYNC;
               clk_cnt_n  = '0;
               last_acc_n = 1'b0;
               snd        = 1'b1;
               snd_bit    = SYNC_PATTERN[0];
               shreg_n    = SYNC_PATTERN >> 1;
               bit_cnt_n  = BIT_W'(1);
`ifdef USB_TX_CRC16_EN
               crc_n      = '1;
               pid_seen_n = 1'b0;
               crc_idx_n  = '0;
`endif
            end
         end
         S_SYNC, S_DATA: begin
            clk_cnt_n = strobe ? '0 : clk_cnt_q + CNT_W'(1);
            if (strobe) begin
               if (state_q == S_DATA && ones_q == ONES_W'(STUFF_RUN)) begin
                  snd     = 1'b1;
                  snd_bit = 1'b0;
               end else if (bit_cnt_q != BIT_W'(DATA_W)) begin
                  snd       = 1'b1;
                  snd_bit   = shreg_q[0];
                  shreg_n   = shreg_q >> 1;
                  bit_cnt_n = bit_cnt_q + BIT_W'(1);
               end else if (hold_full_q) begin
                  load  = 1'b1;
                  drain = 1'b1;
`ifdef USB_TX_CRC16_EN
               end else if (last_acc_q && crc_idx_q != 2'd2) begin
                  load      = 1'b1;
                  load_byte = (crc_idx_q == 2'd0) ? DATA_W'(~crc_q) : DATA_W'((~crc_q) >> 8);
                  crc_idx_n = crc_idx_q + 2'd1;
`endif
               end else begin
                  state_n    = S_EOP;
                  eop_cnt_n  = '0;
                  dp_n       = 1'b0;
                  dm_n       = 1'b0;
                  underrun_n = ~last_acc_q;
               end
            end
         end
         S_EOP: begin
            clk_cnt_n = strobe ? '0 : clk_cnt_q + CNT_W'(1);
            if (strobe) begin
               case (eop_cnt_q)
                  2'd0: eop_cnt_n = 2'd1;
                  2'd1: begin
                     eop_cnt_n = 2'd2;
                     lvl_n     = 1'b1;
                     dp_n      = 1'b1;
                     dm_n      = 1'b0;
                  end
                  default: begin
                     state_n   = S_IDLE;
                     eop_cnt_n = '0;
                     ones_n    = '0;
                     bit_cnt_n = '0;
                     clk_cnt_n = '0;
                  end
               endcase
            end
         end
      endcase

      if (load) begin
         snd       = 1'b1;
         snd_bit   = load_byte[0];
         shreg_n   = load_byte >> 1;
         bit_cnt_n = BIT_W'(1);
         state_n   = S_DATA;
      end

      // NRZI: a 0 toggles the line, a 1 holds it
      if (snd) begin
         lvl_n  = snd_bit ? lvl_q : ~lvl_q;
         ones_n = !snd_bit ? '0 :
                  (ones_q < ONES_W'(STUFF_RUN)) ? ones_q + ONES_W'(1) : ones_q;
         dp_n   = lvl_n;
         dm_n   = ~lvl_n;
      end

      hold_full_n = accept | (hold_full_q & ~drain);
      if (accept) begin
         hold_n = tx_data;
         if (tx_last) last_acc_n = 1'b1;
      end
`ifdef USB_TX_CRC16_EN
      if (accept) begin
         pid_seen_n = 1'b1;
         if (pid_seen_q) crc_n = crc16_upd(crc_q, tx_data);
      end
`endif

      busy_n     = (state_n != S_IDLE);
      oe_n       = busy_n;
      tx_ready_n = ~hold_full_n & ~last_acc_n & (state_n == S_SYNC || state_n == S_DATA);
   end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: table of packets with an expected line-symbol scoreboard.
`timescale 1ns/1ps
module tb_usb_tx_serializer;
   localparam int unsigned CPB  = 4;
   localparam logic [7:0]  SYNC = 8'h80;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, dp_out, dm_out, tx_oe, busy, underrun;

   int n_vec = 0;
   int n_err = 0;
   logic [1:0] exp_q[$];

   typedef struct {
      logic [31:0] d;
      int          n;
      bit          last;
      int          exp_busy;
      int          crc_busy;
      bit          exp_und;
      bit          poke;
   } vec_t;

   vec_t vt[9];

   always #5 clk = ~clk;

   usb_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STUFF_RUN(6), .SYNC_PATTERN(SYNC)) dut (
      .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(tx_ready), .dp_out(dp_out), .dm_out(dm_out), .tx_oe(tx_oe),
      .busy(busy), .underrun(underrun));

   function automatic vec_t mk(input logic [31:0] d, input int n, input bit last, input int eb,
                               input int cb, input bit und, input bit poke);
      vec_t v;
      v.d = d; v.n = n; v.last = last; v.exp_busy = eb; v.crc_busy = cb; v.exp_und = und; v.poke = poke;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard fill: SYNC, bytes with stuffing, NRZI from J, then SE0 SE0 J
   task automatic push_expected(input vec_t v);
      bit         s[$];
      logic [7:0] bl[$];
      int         ones;
      logic       b, lvl;
`ifdef USB_TX_CRC16_EN
      logic [15:0] crc;
      logic        fb;
      int          nb;
`endif
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         s.push_back(SYNC[i]);
         ones = SYNC[i] ? ones + 1 : 0;
      end
      for (int k = 0; k < v.n; k++) bl.push_back(v.d[8*k +: 8]);
`ifdef USB_TX_CRC16_EN
      if (v.last) begin
         crc = 16'hFFFF;
         nb  = bl.size();
         for (int k = 1; k < nb; k++)
            for (int j = 0; j < 8; j++) begin
               fb  = crc[0] ^ bl[k][j];
               crc = crc >> 1;
               if (fb) crc = crc ^ 16'hA001;
            end
         crc = ~crc;
         bl.push_back(crc[7:0]);
         bl.push_back(crc[15:8]);
      end
`endif
      foreach (bl[k])
         for (int j = 0; j < 8; j++) begin
            b = bl[k][j];
            s.push_back(b);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
               s.push_back(1'b0);
               ones = 0;
            end
         end
      lvl = 1'b1;
      foreach (s[i]) begin
         if (!s[i]) lvl = ~lvl;
         exp_q.push_back({lvl, ~lvl});
      end
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
   endtask

   // Byte source: holds tx_valid until each byte is taken
   task automatic feeder(input vec_t v);
      int g;
      for (int i = 0; i < v.n; i++) begin
         tx_data  = v.d[8*i +: 8];
         tx_valid = 1'b1;
         tx_last  = v.last && (i == v.n - 1);
         g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (!tx_ready && g < 3000);
         if (!tx_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: byte %0d never accepted", i);
            break;
         end
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      if (v.last) begin
         @(negedge clk);
         check("ready_after_last", 32'(tx_ready), 32'd0);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int nsym, busy_cnt, und_cnt, und_k, acc_cnt, tail, exp_b;
      logic [1:0] e;
      busy_cnt = 0; und_cnt = 0; und_k = -1; acc_cnt = 0;
      exp_q.delete();
      push_expected(v);
      nsym = exp_q.size();
      @(posedge clk); #1 tx_start = 1'b1;
      @(posedge clk); #1 tx_start = 1'b0;
      fork
         feeder(v);
         begin
            if (v.poke) begin
               repeat (40) @(posedge clk);
               #1 tx_start = 1'b1;
               @(posedge clk);
               #1 tx_start = 1'b0;
            end
         end
         begin
            for (int k = 0; k < nsym * int'(CPB); k++) begin
               @(negedge clk);
               if (busy) busy_cnt++;
               if (underrun) begin und_cnt++; und_k = k; end
               if (tx_valid && tx_ready) acc_cnt++;
               e = (exp_q.size() != 0) ? exp_q[0] : 2'b10;
               check("line", 32'({dp_out, dm_out}), 32'(e));
               if (k % int'(CPB) == int'(CPB) - 1 && exp_q.size() != 0) void'(exp_q.pop_front());
            end
         end
      join
      tail = 0;
      @(negedge clk);
      while (busy && tail < 40) begin
         busy_cnt++;
         if (underrun) und_cnt++;
         tail++;
         @(negedge clk);
      end
      exp_b = v.exp_busy;
`ifdef USB_TX_CRC16_EN
      if (v.last) exp_b = (v.crc_busy != 0) ? v.crc_busy : nsym * int'(CPB);
`endif
      check("busy_cycles", 32'(busy_cnt), 32'(exp_b));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_oe", 32'(tx_oe), 32'd0);
      check("idle_line", 32'({dp_out, dm_out}), 32'b10);
      check("underrun_cnt", 32'(und_cnt), 32'(v.exp_und));
      if (v.exp_und) check("underrun_pos", 32'(und_k), 32'((nsym - 3) * int'(CPB)));
      check("accepted", 32'(acc_cnt), 32'(v.n));
      repeat (3) @(posedge clk);
   endtask

   initial begin
      // {bytes, count, last, busy cycles, busy with CRC (0 = from model), underrun, tx_start poke}
      vt[0] = mk(32'h0000_00D2, 1, 1, 76, 0, 0, 0);
      vt[1] = mk(32'h0000_FFC3, 2, 1, 112, 0, 0, 0);
      vt[2] = mk(32'h810F_3CA5, 4, 1, 172, 0, 0, 1);
      vt[3] = mk(32'h0000_0069, 1, 0, 76, 0, 1, 0);
      vt[4] = mk(32'h0000_FFFF, 2, 1, 116, 0, 0, 0);
      vt[5] = mk(32'h0000_007E, 1, 1, 80, 0, 0, 0);
      vt[6] = mk(32'h0000_00FC, 1, 1, 80, 0, 0, 0);
      vt[7] = mk(32'h0000_3412, 2, 0, 108, 0, 1, 0);
      vt[8] = mk(32'h0000_00C3, 1, 1, 76, 140, 0, 0);

      #2 n_rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dp", 32'(dp_out), 32'd1);
      check("rst_dm", 32'(dm_out), 32'd0);
      check("rst_oe", 32'(tx_oe), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(vt[i]);

      // Reset asserted in the middle of DATA
      @(posedge clk); #1 tx_start = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1; tx_last = 1'b0;
      @(posedge clk); #1 tx_start = 1'b0;
      repeat (45) @(posedge clk);
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_oe", 32'(tx_oe), 32'd1);
      #2 n_rst = 1'b0;
      #1;
      check("arst_dp", 32'(dp_out), 32'd1);
      check("arst_dm", 32'(dm_out), 32'd0);
      check("arst_oe", 32'(tx_oe), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_ready", 32'(tx_ready), 32'd0);
      tx_valid = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_line", 32'({dp_out, dm_out}), 32'b10);
      run_vec(vt[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
Next-generation USB full-speed transmit serializer. It generalises the fixed 8-bit parallel-to-serial shifter into a complete packet transmitter:
- byte-stream valid/ready input with a one-byte holding buffer
- automatic SYNC, LSB-first shifting, bit stuffing, NRZI encoding and EOP generation
- programmable bit-time divider

It sits between the TX packet controller (PID/data/CRC byte source) and the D+/D- pad drivers.

Parameters:
DATA_W, 8, byte width of tx_data and of the shift register; must be >= 2
CLKS_PER_BIT, 4, clk cycles per USB bit time; must be >= 2
STUFF_RUN, 6, consecutive 1 data bits after which a 0 is stuffed
SYNC_PATTERN, 8'h80, DATA_W-bit pattern sent LSB-first at packet start

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tx_start  input  1  single-cycle pulse in IDLE that begins a packet; ignored when busy=1
tx_data  input  DATA_W  next byte to send, LSB transmitted first
tx_valid  input  1  tx_data valid
tx_last  input  1  qualifies tx_data as final byte of the packet
tx_ready  output  1  holding buffer empty and packet still open; byte accepted when tx_valid & tx_ready
dp_out  output  1  D+ line level
dm_out  output  1  D- line level
tx_oe  output  1  pad output enable
busy  output  1  high from the cycle after tx_start until the end of the EOP J bit
underrun  output  1  one-cycle pulse when the shifter empties with no byte held and tx_last not yet accepted

Behaviour:
- Reset: clk and n_rst as stated above (clock clk; reset n_rst, asynchronous, active-low). Reset forces the following, immediately and mid-packet included:
  - state = IDLE
  - dp_out = 1, dm_out = 0 (idle J), tx_oe = 0
  - tx_ready = 0, busy = 0, underrun = 0
  - holding buffer empty, bit counter 0, ones counter 0
- Bit strobe: a counter runs 0..CLKS_PER_BIT-1 while busy. The strobe occurs at count CLKS_PER_BIT-1. Line outputs (dp_out, dm_out) are registered and change only on a strobe, or on IDLE->SYNC entry.
- States and transitions:
  - IDLE: tx_start=1 -> SYNC. The shifter loads SYNC_PATTERN, and the first SYNC bit appears on the line at the next edge. tx_oe=1 from that edge.
  - SYNC: shifts DATA_W bits, no stuffing.
    - Ones counter = 1 on exit (the final SYNC bit is 1).
    - On exit, if the buffer holds a byte -> DATA. Otherwise -> EOP with an underrun pulse.
  - DATA: on each strobe:
    - If ones_cnt == STUFF_RUN: send a 0 (line toggles), set ones_cnt = 0, and do not advance the shifter.
    - Otherwise: send shifter bit 0 and shift right. ones_cnt increments on a 1 and clears on a 0.
    - After the last bit of a byte, load the next byte from the buffer. If the buffer is empty and tx_last was accepted -> EOP. If the buffer is empty and tx_last was not accepted -> EOP plus an underrun pulse.
    - A stuff bit pending after the final data bit is sent before EOP.
  - EOP: SE0 (dp=0, dm=0) for 2 bit times, then J (dp=1, dm=0) for 1 bit time, then -> IDLE with tx_oe=0 and busy=0.
- NRZI: a 0 toggles the line between J (1,0) and K (0,1); a 1 holds the line. The line is J before SYNC.
- Handshake:
  - tx_ready = !hold_full, gated to SYNC/DATA and to tx_last not yet accepted.
  - tx_ready is 0 in IDLE/EOP.
  - In the same cycle, the shifter may drain the buffer and accept a new byte; the buffer then holds the new byte.
  - tx_valid with tx_ready=0 is ignored. There is no data loss for a source that holds tx_valid.
- tx_start while busy: ignored, with no effect on the current packet.

Optional Feature:
USB_TX_CRC16_EN
- Defined: a CRC16 (poly 0x8005, init 0xFFFF, reflected, output inverted) runs over every accepted byte except the first (the PID). After the tx_last byte, the two CRC bytes are sent low byte first, with stuffing applied, and then EOP. tx_ready stays 0 during CRC transmission.
- Undefined: no CRC logic; bytes are sent verbatim and EOP follows the tx_last byte.

Test Plan:
1. CLKS_PER_BIT=4. tx_start, then hold byte 8'hD2 with tx_last -> line shows SYNC KJKJKJKK, 8 PID bits NRZI-correct, SE0 for 8 cycles, J for 4 cycles. busy is high for exactly 76 cycles. No underrun.
2. Bytes 8'hC3 then 8'hFF (last) -> exactly one stuffed 0 (a line toggle) after the 4th bit of 8'hFF. busy duration is one bit time longer than the unstuffed count.
3. Four bytes with tx_valid held high, last on the 4th -> no idle bit gaps between bytes. Each byte is accepted exactly once. tx_ready=0 after the 4th is accepted.
4. tx_start plus PID byte, then tx_valid=0 -> underrun pulses for 1 cycle at the end of the PID. EOP follows, then IDLE.
5. Assert n_rst mid-DATA -> same-cycle dp=1, dm=0, tx_oe=0, busy=0, tx_ready=0. A fresh tx_start after release sends a clean packet.
6. With USB_TX_CRC16_EN, PID 8'hC3 only with tx_last -> two appended bytes 8'h00, 8'h00 (with stuffing), then EOP. Without the macro -> EOP directly after the PID.
